binary_display_renderer: RTL and testbench
==========================================

Name: binary_display_renderer

Overview:
- Parametrised successor to the calculator's operand/result VGA text block.
- Draws NUM_CH channels as rows of WIDTH binary-digit glyphs on a flat background.
- Sits between the calculator datapath and display_controller, and takes that controller's hCount/vCount/bright.
- Adds over the previous generation: frame-synchronous value snapshot (no tearing), blinking error background, per-channel leading-zero blanking, and a registered 2-stage pixel pipeline.

Parameters:
- NUM_CH, 3: number of displayed channels (1..8).
- WIDTH, 16: bits per channel (1..32).
- H_START, 200: hCount of the left edge of cell 0.
- ROW_START, 100: vCount of the top of channel 0.
- ROW_PITCH, 50: vertical spacing between channel tops. Must be >= 10.
- BLINK_FRAMES, 30: frames per blink half-period. Must be >= 1.
- FG, 12'h000: glyph colour.
- BG, 12'hFFF: normal background.
- ERR_BG, 12'hF00: error background.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- bright  input  1  display-area valid from display_controller
- hCount  input  10  current pixel column
- vCount  input  10  current pixel row
- vals  input  NUM_CH*WIDTH  channel values; channel c = vals[c*WIDTH +: WIDTH]
- flag  input  1  error/overflow state
- lz_blank  input  1  1 = blank leading zeros
- rgb  output  12  registered pixel colour

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rgb=0, all shadow values=0, shadow flag=0, shadow lz_blank=0, frame counter=0, blink phase=0, pipeline valid/bright bits=0.
- Reset mid-frame: rgb is black while rst is high. The first rendered frame after release shows all channels as zeros until the next snapshot.

Snapshot:
- Snapshot pulse sof = (hCount==0 && vCount==0), sampled on the clock edge.
- On sof, latch vals, flag and lz_blank into shadow registers. Also latch, per channel, lead[c] = index of the highest set bit, or 0 if the value is 0.
- All rendering uses shadow values only. Changes to vals mid-frame never appear until the next frame.

Blink:
- On sof with shadow flag (the pre-latch value) = 1: increment the frame counter.
- When the counter reaches BLINK_FRAMES-1: wrap it to 0 and toggle phase.
- On sof with shadow flag = 0: counter=0 and phase=0.
- Background = ERR_BG when shadow flag=1 and phase=0, else BG. The first error frame therefore shows ERR_BG.

Geometry (all ranges half-open):
- Channel c occupies vCount in [ROW_START+c*ROW_PITCH, +10).
- Cell k occupies hCount in [H_START+10k, +10), for k=0..WIDTH-1.
- Cell k displays bit WIDTH-1-k, so the MSB is leftmost.
- In-cell coordinates: col = hCount-cell_left, row = vCount-row_top, each 0..9.
- Outside all cells: background.

Glyphs:
- "1": fill at col in {4,5} and row in 1..8.
- "0": fill at col in {1,2,7,8} with row in 3..6, and at col in 3..6 with row in {1,2,7,8}.
- Every other cell pixel is background.

Leading-zero blanking:
- When shadow lz_blank=1, cells showing bit index > lead[c] render as background.
- Bit 0 is always drawn, so a value of 0 shows a single "0".

Pipeline (latency 2):
- Stage 1 registers: in_region, channel index, bit index, col, row, bright.
- Stage 2 does the glyph lookup and registers rgb.
- rgb at edge t+2 corresponds to the hCount/vCount/bright sampled at edge t.
- rgb = 0 whenever the delayed bright = 0, regardless of position.

Arithmetic:
- No modulo operators on hCount/vCount. Use subtraction and compare against the parameter-derived bounds, computed at elaboration.

Test Plan:
- Reset, then vals={16'h0000,16'h0000,16'h8001}, flag=0, lz_blank=0, one frame:
  - pixel (h=204,v=105) -> rgb=000 two cycles later (ch0 MSB "1").
  - (h=201,v=153) -> 000 (ch1 bit15 "0" at col1,row3).
  - (h=200,v=100) -> FFF.
  - bright=0 anywhere -> 000.
- Change vals[15:0] to 16'hFFFF at vCount=300: remainder of the frame unchanged. The next frame shows all ch0 cells as "1".
- flag=1 held, BLINK_FRAMES=2: background per frame = F00,F00,FFF,FFF,F00. Drop flag -> FFF from the next frame onward, and phase restarts at F00 on re-assert.
- lz_blank=1, ch0=16'h0005: cells k=0..12 all background; cells 13,14,15 show 1,0,1. ch1=0 shows only cell 15 as "0".
- Row/cell boundaries: h=H_START+10*WIDTH=360 and v=110 are background. (h=359,v=109) is in-cell (col9,row9, background).
- Assert rst asynchronously mid-line -> rgb=000 immediately, without waiting for a clock edge. After release, the frame shows zeros until the next sof.

Source files
------------

// File: rtl/binary_display_renderer.sv
// binary_display_renderer: draws NUM_CH channel values as rows of binary-digit glyphs,
// with frame-synchronous snapshot, blinking error background and leading-zero blanking.
module binary_display_renderer #(
    parameter int          NUM_CH       = 3,
    parameter int          WIDTH        = 16,
    parameter int          H_START      = 200,
    parameter int          ROW_START    = 100,
    parameter int          ROW_PITCH    = 50,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG           = 12'h000,
    parameter logic [11:0] BG           = 12'hFFF,
    parameter logic [11:0] ERR_BG       = 12'hF00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bright,
    input  logic [9:0]              hCount,
    input  logic [9:0]              vCount,
    input  logic [NUM_CH*WIDTH-1:0] vals,
    input  logic                    flag,
    input  logic                    lz_blank,
    output logic [11:0]             rgb
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [NUM_CH*WIDTH-1:0] r_vals;
    logic                    r_flag, r_lz, r_phase;
    logic [CW-1:0]           r_cnt;
    logic [4:0]              r_lead [NUM_CH];
    logic [4:0]              w_lead [NUM_CH];
    logic                    w_sof;

    assign w_sof = hCount == 10'd0 && vCount == 10'd0;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_lead[c] = '0;
            for (int b = 0; b < WIDTH; b++)
                if (vals[c*WIDTH+b]) w_lead[c] = 5'(b);
        end
    end

    // Blink state advances on the flag value that governed the frame just ending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vals  <= '0;
            r_flag  <= 1'b0;
            r_lz    <= 1'b0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_lead  <= '{default: '0};
        end else if (w_sof) begin
            r_vals <= vals;
            r_flag <= flag;
            r_lz   <= lz_blank;
            r_lead <= w_lead;
            if (!r_flag) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt == CW'(BLINK_FRAMES - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    logic       w_hit_row, w_hit_col;
    logic [2:0] w_ch;
    logic [4:0] w_bit;
    logic [3:0] w_col, w_row;

    always_comb begin
        w_hit_row = 1'b0;
        w_hit_col = 1'b0;
        w_ch      = '0;
        w_bit     = '0;
        w_col     = '0;
        w_row     = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(vCount) >= ROW_START + c*ROW_PITCH && int'(vCount) < ROW_START + c*ROW_PITCH + 10) begin
                w_hit_row = 1'b1;
                w_ch      = 3'(c);
                w_row     = 4'(int'(vCount) - ROW_START - c*ROW_PITCH);
            end
        for (int k = 0; k < WIDTH; k++)
            if (int'(hCount) >= H_START + 10*k && int'(hCount) < H_START + 10*k + 10) begin
                w_hit_col = 1'b1;
                w_bit     = 5'(WIDTH - 1 - k);
                w_col     = 4'(int'(hCount) - H_START - 10*k);
            end
    end

    logic       r1_in, r1_bright;
    logic [2:0] r1_ch;
    logic [4:0] r1_bit;
    logic [3:0] r1_col, r1_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_in     <= 1'b0;
            r1_bright <= 1'b0;
            r1_ch     <= '0;
            r1_bit    <= '0;
            r1_col    <= '0;
            r1_row    <= '0;
        end else begin
            r1_in     <= w_hit_row && w_hit_col;
            r1_bright <= bright;
            r1_ch     <= w_ch;
            r1_bit    <= w_bit;
            r1_col    <= w_col;
            r1_row    <= w_row;
        end
    end

    logic [31:0] w_chval;
    logic [4:0]  w_lead_sel;
    logic        w_one, w_zero, w_fill;
    logic [11:0] w_bg;

    always_comb begin
        w_chval    = '0;
        w_lead_sel = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r1_ch == 3'(c)) begin
                w_chval    = 32'(r_vals[c*WIDTH +: WIDTH]);
                w_lead_sel = r_lead[c];
            end
    end

    assign w_one  = (r1_col == 4'd4 || r1_col == 4'd5) && r1_row >= 4'd1 && r1_row <= 4'd8;
    assign w_zero = ((r1_col == 4'd1 || r1_col == 4'd2 || r1_col == 4'd7 || r1_col == 4'd8) && r1_row >= 4'd3 && r1_row <= 4'd6)
                 || (r1_col >= 4'd3 && r1_col <= 4'd6 && (r1_row == 4'd1 || r1_row == 4'd2 || r1_row == 4'd7 || r1_row == 4'd8));
    assign w_fill = r1_in && !(r_lz && r1_bit > w_lead_sel) && (w_chval[r1_bit] ? w_one : w_zero);
    assign w_bg   = (r_flag && !r_phase) ? ERR_BG : BG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= 12'h000;
        else     rgb <= !r1_bright ? 12'h000 : w_fill ? FG : w_bg;
    end
endmodule

// File: tb/tb_binary_display_renderer.sv
// tb_binary_display_renderer: directed checks of rendering, snapshot, blink, blanking and reset.
module tb_binary_display_renderer;
    logic        clk = 1'b0;
    logic        rst, bright, flag, lz_blank;
    logic [9:0]  hCount, vCount;
    logic [47:0] vals;
    logic [11:0] rgb;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    binary_display_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
        .vals(vals), .flag(flag), .lz_blank(lz_blank), .rgb(rgb)
    );

    task automatic px(input int h, input int v, input logic b);
        @(negedge clk);
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        @(negedge clk);
        hCount = 10'd0;
        vCount = 10'd0;
        bright = 1'b0;
        @(posedge clk);
        @(negedge clk);
        hCount = 10'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bright = 1'b1; hCount = 10'd200; vCount = 10'd100;
        vals = '0; flag = 1'b0; lz_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rgb !== 12'h000) $display("FAIL reset_rgb: rgb=%h expected 000", rgb); else passed++;
        @(negedge clk);
        rst = 1'b0;
        px(204, 105, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL reset_zero_glyph_gap: rgb=%h expected FFF", rgb); else passed++;
        px(201, 103, 1'b1);
        total++;
        if (rgb !== 12'h000) $display("FAIL reset_zero_glyph_fill: rgb=%h expected 000", rgb); else passed++;
    endtask

    task automatic test_basic();
        int          th [10] = '{204, 201, 200, 200, 354, 201, 360, 204, 359, 199};
        int          tv [10] = '{105, 153, 100, 100, 105, 203, 105, 110, 109, 105};
        logic        tb_ [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [11:0] te [10] = '{12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000,
                                 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vals = 48'h0000_0000_8001;
        new_frame();
        for (int i = 0; i < 10; i++) begin
            px(th[i], tv[i], tb_[i]);
            total++;
            if (rgb !== te[i]) $display("FAIL basic_%0d (h=%0d v=%0d b=%0b): rgb=%h expected %h",
                                        i, th[i], tv[i], tb_[i], rgb, te[i]);
            else passed++;
        end
    endtask

    task automatic test_snapshot();
        vals[15:0] = 16'hFFFF;
        px(214, 300, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL snap_outside: rgb=%h expected FFF", rgb); else passed++;
        px(214, 105, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL snap_no_tear: rgb=%h expected FFF", rgb); else passed++;
        new_frame();
        px(214, 105, 1'b1);
        total++;
        if (rgb !== 12'h000) $display("FAIL snap_next_one: rgb=%h expected 000", rgb); else passed++;
        px(201, 103, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL snap_next_gap: rgb=%h expected FFF", rgb); else passed++;
    endtask

    task automatic test_blink();
        logic        tf [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic [11:0] te [9] = '{12'hF00, 12'hF00, 12'hFFF, 12'hFFF, 12'hF00,
                                12'hF00, 12'hFFF, 12'hFFF, 12'hF00};
        for (int i = 0; i < 9; i++) begin
            flag = tf[i];
            new_frame();
            px(200, 100, 1'b1);
            total++;
            if (rgb !== te[i]) $display("FAIL blink_frame_%0d: rgb=%h expected %h", i, rgb, te[i]);
            else passed++;
        end
        flag = 1'b0;
        new_frame();
    endtask

    task automatic test_lz();
        int          th [8] = '{201, 261, 321, 334, 341, 354, 341, 351};
        int          tv [8] = '{103, 103, 103, 105, 103, 105, 153, 153};
        logic [11:0] te [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000};
        vals = 48'h0000_0000_0005;
        lz_blank = 1'b1;
        new_frame();
        for (int i = 0; i < 8; i++) begin
            px(th[i], tv[i], 1'b1);
            total++;
            if (rgb !== te[i]) $display("FAIL lz_%0d (h=%0d v=%0d): rgb=%h expected %h",
                                        i, th[i], tv[i], rgb, te[i]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        vals = 48'h0000_0000_FFFF;
        new_frame();
        px(200, 100, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL arst_before: rgb=%h expected FFF", rgb); else passed++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (rgb !== 12'h000) $display("FAIL arst_immediate: rgb=%h expected 000", rgb); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        px(201, 103, 1'b1);
        total++;
        if (rgb !== 12'h000) $display("FAIL arst_zero_fill: rgb=%h expected 000", rgb); else passed++;
        px(204, 105, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL arst_zero_gap: rgb=%h expected FFF", rgb); else passed++;
        new_frame();
        px(204, 105, 1'b1);
        total++;
        if (rgb !== 12'h000) $display("FAIL arst_next_one: rgb=%h expected 000", rgb); else passed++;
        px(201, 103, 1'b1);
        total++;
        if (rgb !== 12'hFFF) $display("FAIL arst_next_gap: rgb=%h expected FFF", rgb); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_blink();
        test_lz();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
